// File: rtl/network_pkg.sv
// Shared width constants and FSM encoding for the sequential signed divider.
package network_pkg;

    localparam int SDIV_DIVIDEND_W = 29;
    localparam int SDIV_DIVISOR_W  = 13;
    localparam int SDIV_QUOT_W     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/network_sdiv_29s_13s_16_seq_if.sv
// Operand/result handshake bundle for the sequential signed divider.
// valid/ready: a transfer happens on a rising edge where ce=1 and both valid and ready are 1.
interface network_sdiv_29s_13s_16_seq_if #(
    parameter int DIVIDEND_W = 29,
    parameter int DIVISOR_W  = 13,
    parameter int QUOT_W     = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [QUOT_W-1:0]     quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;
    logic                  overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/network_sdiv_sat.sv
// Combinational sign restoration and quotient saturation; feeds the output registers.
module network_sdiv_sat
    import network_pkg::*;
#(
    parameter int DIVIDEND_W = SDIV_DIVIDEND_W,
    parameter int DIVISOR_W  = SDIV_DIVISOR_W,
    parameter int QUOT_W     = SDIV_QUOT_W
) (
    input  logic                  dbz,
    input  logic                  dividend_neg,
    input  logic                  q_neg,
    input  logic [DIVIDEND_W-1:0] q_mag,
    input  logic [DIVISOR_W-1:0]  r_mag,
    output logic [QUOT_W-1:0]     quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);

    // Largest representable magnitudes for a positive and a negative quotient.
    localparam logic [DIVIDEND_W-1:0] POS_LIM =
        {{(DIVIDEND_W-QUOT_W+1){1'b0}}, {(QUOT_W-1){1'b1}}};
    localparam logic [DIVIDEND_W-1:0] NEG_LIM =
        {{(DIVIDEND_W-QUOT_W){1'b0}}, 1'b1, {(QUOT_W-1){1'b0}}};
    localparam logic [QUOT_W-1:0] Q_MAX = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic [QUOT_W-1:0] Q_MIN = {1'b1, {(QUOT_W-1){1'b0}}};

    always_comb begin
        quotient    = '0;
        remainder   = '0;
        div_by_zero = 1'b0;
        overflow    = 1'b0;
        if (dbz) begin
            div_by_zero = 1'b1;
            quotient    = dividend_neg ? Q_MIN : Q_MAX;
        end else begin
            if (q_neg) begin
                if (q_mag > NEG_LIM) begin
                    quotient = Q_MIN;
                    overflow = 1'b1;
                end else begin
                    quotient = -q_mag[QUOT_W-1:0];
                end
            end else begin
                if (q_mag > POS_LIM) begin
                    quotient = Q_MAX;
                    overflow = 1'b1;
                end else begin
                    quotient = q_mag[QUOT_W-1:0];
                end
            end
            // Remainder follows the dividend sign, also when the quotient saturates.
            remainder = dividend_neg ? -r_mag : r_mag;
        end
    end

endmodule

// File: rtl/network_sdiv_29s_13s_16_seq.sv
// Sequential signed divider: one restoring shift-subtract step per enabled clock on magnitudes,
// followed by sign restoration and saturation into registered outputs.
module network_sdiv_29s_13s_16_seq
    import network_pkg::*;
#(
    parameter int DIVIDEND_W = SDIV_DIVIDEND_W,
    parameter int DIVISOR_W  = SDIV_DIVISOR_W,
    parameter int QUOT_W     = SDIV_QUOT_W
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             ce,
    network_sdiv_29s_13s_16_seq_if.slave     bus,
    output state_t                           dbg_state,
    output logic [$clog2(DIVIDEND_W)-1:0]    dbg_count
);

    localparam int CNT_W = $clog2(DIVIDEND_W);

    state_t                state;
    logic [CNT_W-1:0]      count;
    logic [DIVIDEND_W-1:0] quo_r;
    logic [DIVIDEND_W-1:0] rem_r;
    logic [DIVISOR_W-1:0]  dvs_r;
    logic                  q_neg_r;
    logic                  r_neg_r;

    logic                  in_ready_q;
    logic                  out_valid_q;
    logic [QUOT_W-1:0]     quot_q;
    logic [DIVISOR_W-1:0]  rem_q;
    logic                  dbz_q;
    logic                  ovf_q;

    logic [DIVIDEND_W-1:0] dividend_mag;
    logic [DIVISOR_W-1:0]  divisor_mag;
    logic                  dividend_neg;
    logic                  divisor_neg;
    logic                  divisor_zero;

    logic [DIVIDEND_W-1:0] trial;
    logic [DIVIDEND_W:0]   diff;
    logic                  fits;
    logic [DIVIDEND_W-1:0] rem_nx;
    logic [DIVIDEND_W-1:0] quo_nx;

    logic                  sat_dbz;
    logic                  sat_dividend_neg;
    logic [QUOT_W-1:0]     sat_quot;
    logic [DIVISOR_W-1:0]  sat_rem;
    logic                  sat_dbz_flag;
    logic                  sat_ovf;

    // The partial remainder never exceeds the divisor magnitude, so its top bit is never shifted out.
    logic                  unused_rem_msb;
    assign unused_rem_msb = rem_r[DIVIDEND_W-1];

    assign dividend_neg = bus.dividend[DIVIDEND_W-1];
    assign divisor_neg  = bus.divisor[DIVISOR_W-1];
    assign divisor_zero = (bus.divisor == '0);
    assign dividend_mag = dividend_neg ? -bus.dividend : bus.dividend;
    assign divisor_mag  = divisor_neg ? -bus.divisor : bus.divisor;

    // Restoring step: shift the next dividend bit into the partial remainder and try one subtract.
    assign trial  = {rem_r[DIVIDEND_W-2:0], quo_r[DIVIDEND_W-1]};
    assign diff   = {1'b0, trial} - {{(DIVIDEND_W+1-DIVISOR_W){1'b0}}, dvs_r};
    assign fits   = ~diff[DIVIDEND_W];
    assign rem_nx = fits ? diff[DIVIDEND_W-1:0] : trial;
    assign quo_nx = {quo_r[DIVIDEND_W-2:0], fits};

    // From IDLE the only result ever loaded is the divide-by-zero one.
    assign sat_dbz          = (state == IDLE);
    assign sat_dividend_neg = (state == IDLE) ? dividend_neg : r_neg_r;

    network_sdiv_sat #(
        .DIVIDEND_W (DIVIDEND_W),
        .DIVISOR_W  (DIVISOR_W),
        .QUOT_W     (QUOT_W)
    ) u_sat (
        .dbz          (sat_dbz),
        .dividend_neg (sat_dividend_neg),
        .q_neg        (q_neg_r),
        .q_mag        (quo_nx),
        .r_mag        (rem_nx[DIVISOR_W-1:0]),
        .quotient     (sat_quot),
        .remainder    (sat_rem),
        .div_by_zero  (sat_dbz_flag),
        .overflow     (sat_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            quo_r       <= '0;
            rem_r       <= '0;
            dvs_r       <= '0;
            q_neg_r     <= 1'b0;
            r_neg_r     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quot_q      <= '0;
            rem_q       <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (ce) begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        quo_r      <= dividend_mag;
                        rem_r      <= '0;
                        dvs_r      <= divisor_mag;
                        q_neg_r    <= dividend_neg ^ divisor_neg;
                        r_neg_r    <= dividend_neg;
                        in_ready_q <= 1'b0;
                        if (divisor_zero) begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                            quot_q      <= sat_quot;
                            rem_q       <= sat_rem;
                            dbz_q       <= sat_dbz_flag;
                            ovf_q       <= sat_ovf;
                        end else begin
                            state <= CALC;
                            count <= CNT_W'(DIVIDEND_W - 1);
                        end
                    end
                end
                CALC: begin
                    quo_r <= quo_nx;
                    rem_r <= rem_nx;
                    if (count == '0) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        quot_q      <= sat_quot;
                        rem_q       <= sat_rem;
                        dbz_q       <= sat_dbz_flag;
                        ovf_q       <= sat_ovf;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
    assign dbg_state       = state;
    assign dbg_count       = count;

endmodule
